// File: rtl/alu_req_queue.sv
// alu_req_queue: opcode-screening request FIFO in front of the ALU with registered head outputs
module alu_req_queue #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [3:0]                 in_op_i,
    input  logic [DWIDTH-1:0]          in_a_i,
    input  logic [DWIDTH-1:0]          in_b_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [3:0]                 out_op_o,
    output logic [DWIDTH-1:0]          out_a_o,
    output logic [DWIDTH-1:0]          out_b_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       illegal_o,
    output logic [7:0]                 illegal_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]        op_q [DEPTH];
    logic [DWIDTH-1:0] a_q  [DEPTH];
    logic [DWIDTH-1:0] b_q  [DEPTH];
    logic [PW-1:0]     wptr, rptr, wptr_n, rptr_n;
    logic [CW-1:0]     count_n;
    logic              push, legal, wr, pop, head_in;

    assign push    = in_valid_i && in_ready_o && !flush_i;
    assign legal   = in_op_i < 4'd10;
    assign wr      = push && legal;
    assign pop     = out_valid_o && out_ready_i && !flush_i;
    assign head_in = wr && (rptr_n == wptr);

    // Next-state pointers and occupancy; a flush realigns the read pointer onto the write pointer
    always_comb begin
        wptr_n  = wr ? wptr + PW'(1) : wptr;
        rptr_n  = flush_i ? wptr : (pop ? rptr + PW'(1) : rptr);
        count_n = flush_i ? '0 : count_o + CW'(wr) - CW'(pop);
    end

    // Storage array; written only by legal pushes, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (wr) begin
            op_q[wptr] <= in_op_i;
            a_q[wptr]  <= in_a_i;
            b_q[wptr]  <= in_b_i;
        end
    end

    // Control state plus the registered head entry, taken from the incoming request when it becomes the head
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr          <= '0;
            rptr          <= '0;
            count_o       <= '0;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            out_op_o      <= 4'd0;
            out_a_o       <= '0;
            out_b_o       <= '0;
            illegal_o     <= 1'b0;
            illegal_cnt_o <= '0;
        end else begin
            wptr          <= wptr_n;
            rptr          <= rptr_n;
            count_o       <= count_n;
            in_ready_o    <= count_n != CW'(DEPTH);
            out_valid_o   <= count_n != '0;
            out_op_o      <= (count_n == '0) ? out_op_o : (head_in ? in_op_i : op_q[rptr_n]);
            out_a_o       <= (count_n == '0) ? out_a_o  : (head_in ? in_a_i  : a_q[rptr_n]);
            out_b_o       <= (count_n == '0) ? out_b_o  : (head_in ? in_b_i  : b_q[rptr_n]);
            illegal_o     <= push && !legal;
            illegal_cnt_o <= (push && !legal && illegal_cnt_o != 8'hFF) ? illegal_cnt_o + 8'd1 : illegal_cnt_o;
        end
    end
endmodule

// File: tb/tb_alu_req_queue.sv
// tb_alu_req_queue: directed vector table, illegal saturation, random scoreboard run and mid-run reset
module tb_alu_req_queue;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0, in_valid = 0, out_ready = 0;
    logic [3:0]  in_op = 0;
    logic [31:0] in_a = 0, in_b = 0;
    logic        in_ready, out_valid, illegal;
    logic [3:0]  out_op;
    logic [31:0] out_a, out_b;
    logic [2:0]  count;
    logic [7:0]  illegal_cnt;

    int tests = 0;
    int fails = 0;

    alu_req_queue #(.DWIDTH(32), .DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
        .in_a_i(in_a), .in_b_i(in_b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_op_o(out_op), .out_a_o(out_a), .out_b_o(out_b),
        .count_o(count), .illegal_o(illegal), .illegal_cnt_o(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        r, f;
        logic        e_valid;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        int          e_cnt;
        logic        e_rdy, e_ill;
        int          e_icnt;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic f, input logic ev, input logic [3:0] eop, input logic [31:0] ea,
                        input logic [31:0] eb, input int ec, input logic erdy, input logic eill, input int eic);
        vecs[i] = '{v, op, a, b, r, f, ev, eop, ea, eb, ec, erdy, eill, eic};
    endtask

    logic [35+32:0] q[$];
    int  mcnt_ill;
    logic mill;

    initial begin
        // idx  v  op  a   b   r  f | valid op a  b  cnt rdy ill icnt
        setv( 0, 1,  1,  7,  3, 1, 0,  1,  1,  7,  3, 1, 1, 0, 0);
        setv( 1, 0,  0,  0,  0, 1, 0,  0,  1,  7,  3, 0, 1, 0, 0);
        setv( 2, 1,  0, 10, 20, 0, 0,  1,  0, 10, 20, 1, 1, 0, 0);
        setv( 3, 1,  2, 11, 21, 0, 0,  1,  0, 10, 20, 2, 1, 0, 0);
        setv( 4, 1,  3, 12, 22, 0, 0,  1,  0, 10, 20, 3, 1, 0, 0);
        setv( 5, 1,  4, 13, 23, 0, 0,  1,  0, 10, 20, 4, 0, 0, 0);
        setv( 6, 1,  5, 14, 24, 0, 0,  1,  0, 10, 20, 4, 0, 0, 0);
        setv( 7, 1,  5, 14, 24, 1, 0,  1,  2, 11, 21, 3, 1, 0, 0);
        setv( 8, 1,  5, 14, 24, 0, 0,  1,  2, 11, 21, 4, 0, 0, 0);
        setv( 9, 0,  0,  0,  0, 1, 0,  1,  3, 12, 22, 3, 1, 0, 0);
        setv(10, 0,  0,  0,  0, 1, 0,  1,  4, 13, 23, 2, 1, 0, 0);
        setv(11, 0,  0,  0,  0, 1, 0,  1,  5, 14, 24, 1, 1, 0, 0);
        setv(12, 0,  0,  0,  0, 1, 0,  0,  5, 14, 24, 0, 1, 0, 0);
        setv(13, 1, 12, 99, 99, 1, 0,  0,  5, 14, 24, 0, 1, 1, 1);
        setv(14, 0,  0,  0,  0, 1, 0,  0,  5, 14, 24, 0, 1, 0, 1);
        setv(15, 1,  6,  1,  2, 0, 0,  1,  6,  1,  2, 1, 1, 0, 1);
        setv(16, 1,  7,  3,  4, 0, 0,  1,  6,  1,  2, 2, 1, 0, 1);
        setv(17, 1,  8,  5,  6, 0, 0,  1,  6,  1,  2, 3, 1, 0, 1);
        setv(18, 1,  9,  7,  8, 1, 1,  0,  6,  1,  2, 0, 1, 0, 1);
        setv(19, 1,  1, 40, 41, 0, 0,  1,  1, 40, 41, 1, 1, 0, 1);
        setv(20, 1,  2, 42, 43, 1, 0,  1,  2, 42, 43, 1, 1, 0, 1);
        setv(21, 0,  0,  0,  0, 1, 0,  0,  2, 42, 43, 0, 1, 0, 1);
        setv(22, 1, 15,  0,  0, 0, 1,  0,  2, 42, 43, 0, 1, 0, 1);

        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_op", out_op, 0);
        chk("reset_a", out_a, 0);
        chk("reset_icnt", illegal_cnt, 0);
        chk("reset_ill", illegal, 0);
        rst_n = 1;
        step();

        for (int i = 0; i < 23; i++) begin
            in_valid = vecs[i].v; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
            out_ready = vecs[i].r; flush = vecs[i].f;
            step();
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_op", i), out_op, vecs[i].e_op);
            chk($sformatf("v%0d_a", i), out_a, vecs[i].e_a);
            chk($sformatf("v%0d_b", i), out_b, vecs[i].e_b);
            chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("v%0d_ready", i), in_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_ill", i), illegal, vecs[i].e_ill);
            chk($sformatf("v%0d_icnt", i), illegal_cnt, vecs[i].e_icnt);
        end
        flush = 0;

        // 300 illegal pushes saturate the drop counter at 255 without storing anything
        in_valid = 1; out_ready = 0;
        for (int i = 0; i < 300; i++) begin
            in_op = 4'(10 + (i % 6));
            step();
        end
        chk("sat_icnt", illegal_cnt, 255);
        chk("sat_count", count, 0);
        chk("sat_ill", illegal, 1);
        in_valid = 0;
        step();
        chk("sat_ill_drop", illegal, 0);

        // Random traffic against a scoreboard, with an asynchronous reset pulse midway
        rst_n = 0;
        #1;
        rst_n = 1;
        chk("rst2_icnt", illegal_cnt, 0);
        q.delete(); mcnt_ill = 0; mill = 0;
        for (int c = 0; c < 10000; c++) begin
            logic [67:0] head;
            logic p, pp;
            chk("rnd_valid", out_valid, q.size() != 0);
            chk("rnd_count", count, q.size());
            chk("rnd_ready", in_ready, q.size() != 4);
            chk("rnd_ill", illegal, mill);
            chk("rnd_icnt", illegal_cnt, mcnt_ill);
            if (q.size() != 0) begin
                head = q[0];
                chk("rnd_op", out_op, head[67:64]);
                chk("rnd_a", out_a, head[63:32]);
                chk("rnd_b", out_b, head[31:0]);
            end
            if (c == 5000) begin
                rst_n = 0;
                #1;
                chk("midrst_valid", out_valid, 0);
                chk("midrst_count", count, 0);
                chk("midrst_op", out_op, 0);
                chk("midrst_a", out_a, 0);
                chk("midrst_b", out_b, 0);
                chk("midrst_icnt", illegal_cnt, 0);
                chk("midrst_ready", in_ready, 1);
                in_valid = 1; in_op = 1; out_ready = 1;
                step();
                chk("midrst_hold", count, 0);
                rst_n = 1;
                q.delete(); mcnt_ill = 0; mill = 0;
                continue;
            end
            in_valid = $urandom_range(0, 1);
            in_op = (($urandom_range(0, 7) == 0)) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            in_a = $urandom; in_b = $urandom;
            out_ready = $urandom_range(0, 2) != 0;
            p  = in_valid && (q.size() != 4);
            pp = (q.size() != 0) && out_ready;
            step();
            if (pp) void'(q.pop_front());
            mill = p && (in_op >= 10);
            if (mill && mcnt_ill != 255) mcnt_ill++;
            if (p && in_op < 10) q.push_back({in_op, in_a, in_b});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
